// File: rtl/axi_rd_arbiter.sv
// Two-master single-beat AXI read arbiter: fetch (i_*) and load/store (d_*)
// share one memory read port with one transaction in flight at a time.
// A watchdog turns a lost response into SLVERR and drains the late beat.
module axi_rd_arbiter #(
  parameter int unsigned FAIR    = 1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch master
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic [1:0]  i_rresp,
  output logic        i_rvalid,
  input  logic        i_rready,
  // load/store master
  input  logic [31:0] d_araddr,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic [1:0]  d_rresp,
  output logic        d_rvalid,
  input  logic        d_rready,
  // memory port
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  // current owner: 01 = i, 10 = d
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WDOG_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_wdog;
  logic             r_err;
  logic             r_last_d;
  logic [1:0]       r_gnt;
  logic             r_arvalid;
  logic [31:0]      r_araddr;

  logic        w_idle;
  logic        w_wait;
  logic        w_pick_d;
  logic        w_pick_i;
  logic        w_to;
  logic        w_err;
  logic        w_own_rready;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;

  // Gating with rst_n keeps every combinational handshake low while in reset.
  assign w_idle = rst_n && (r_state == S_IDLE);
  assign w_wait = rst_n && (r_state == S_WAIT_R);

  // d wins when alone, when priority is fixed, or when i was served last.
  assign w_pick_d = d_arvalid && (!i_arvalid || (FAIR == 0) || !r_last_d);
  assign w_pick_i = i_arvalid && !w_pick_d;

  // Watchdog expiry; a beat arriving in the expiry cycle wins over the error.
  // Once the error has been presented it is held (r_err) until accepted.
  assign w_to  = (TIMEOUT != 0) && (r_wdog == TO_VAL);
  assign w_err = r_err || (w_to && !m_rvalid);

  assign w_own_rready = r_gnt[0] ? i_rready : d_rready;
  assign w_rvalid     = w_err || m_rvalid;
  assign w_rdata      = w_err ? 32'd0 : m_rdata;
  assign w_rresp      = w_err ? 2'b10 : m_rresp;

  assign i_arready = w_idle && w_pick_i;
  assign d_arready = w_idle && w_pick_d;

  assign i_rvalid = w_wait && r_gnt[0] && w_rvalid;
  assign d_rvalid = w_wait && r_gnt[1] && w_rvalid;
  assign i_rdata  = w_rdata;
  assign d_rdata  = w_rdata;
  assign i_rresp  = w_rresp;
  assign d_rresp  = w_rresp;

  // Memory is back-pressured directly by the owner; no buffering here.
  assign m_rready = rst_n && (((r_state == S_WAIT_R) && !w_err && w_own_rready) ||
                              (r_state == S_DRAIN));

  assign m_arvalid = r_arvalid;
  assign m_araddr  = r_araddr;
  assign gnt       = r_gnt;

  // Arbitration FSM: grant, issue address, route response, drain after timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wdog    <= '0;
      r_err     <= 1'b0;
      r_last_d  <= 1'b1;
      r_gnt     <= 2'b00;
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_i || w_pick_d) begin
            r_araddr  <= w_pick_d ? d_araddr : i_araddr;
            r_gnt     <= w_pick_d ? 2'b10 : 2'b01;
            r_last_d  <= w_pick_d;
            r_arvalid <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
            r_state   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (w_err) begin
            if (w_own_rready) begin
              r_err   <= 1'b0;
              r_gnt   <= 2'b00;
              r_state <= S_DRAIN;
            end else begin
              r_err <= 1'b1;
            end
          end else if (m_rvalid && w_own_rready) begin
            r_gnt   <= 2'b00;
            r_state <= S_IDLE;
          end else if (!w_to && (r_wdog != WDOG_MAX)) begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (m_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: two instances (round-robin with TIMEOUT=4, fixed
// priority with watchdog off) share one directed stimulus; a transaction-level
// model predicts every output each cycle, and literal checks pin key moments.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_araddr, d_araddr, m_rdata;
  logic        i_arvalid, d_arvalid, i_rready, d_rready, m_arready, m_rvalid;
  logic [1:0]  m_rresp;

  logic        o_iar [2];
  logic        o_dar [2];
  logic        o_ivl [2];
  logic        o_dvl [2];
  logic        o_mav [2];
  logic        o_mrr [2];
  logic [31:0] o_ird [2];
  logic [31:0] o_drd [2];
  logic [31:0] o_mad [2];
  logic [1:0]  o_irr [2];
  logic [1:0]  o_drr [2];
  logic [1:0]  o_gnt [2];

  int checks = 0;
  int errors = 0;

  int glog0[$];
  int glog1[$];

  always #5 clk = ~clk;

  axi_rd_arbiter #(.FAIR(1), .TIMEOUT(4), .CNT_W(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(o_iar[0]),
    .i_rdata(o_ird[0]), .i_rresp(o_irr[0]), .i_rvalid(o_ivl[0]), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(o_dar[0]),
    .d_rdata(o_drd[0]), .d_rresp(o_drr[0]), .d_rvalid(o_dvl[0]), .d_rready(d_rready),
    .m_araddr(o_mad[0]), .m_arvalid(o_mav[0]), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(o_mrr[0]),
    .gnt(o_gnt[0])
  );

  axi_rd_arbiter #(.FAIR(0), .TIMEOUT(0), .CNT_W(8)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(o_iar[1]),
    .i_rdata(o_ird[1]), .i_rresp(o_irr[1]), .i_rvalid(o_ivl[1]), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(o_dar[1]),
    .d_rdata(o_drd[1]), .d_rresp(o_drr[1]), .d_rvalid(o_dvl[1]), .d_rready(d_rready),
    .m_araddr(o_mad[1]), .m_arvalid(o_mav[1]), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(o_mrr[1]),
    .gnt(o_gnt[1])
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit fair_of(input int k);
    return (k == 0);
  endfunction

  function automatic int to_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  // Transaction-level model: each arbiter is either free, has an address
  // outstanding, is awaiting data (counting idle cycles), or is discarding.
  // Expected outputs follow from that plus the current inputs.
  int          mstage [2];  // 0 free, 1 addr out, 2 awaiting data, 3 discard
  int          mowner [2];  // 1 = i, 2 = d
  int          mwaited[2];
  bit          mlastd [2];
  bit          merrh  [2];
  logic [31:0] maddr  [2];
  logic [1:0]  mprev_g[2];

  initial begin
    int win, e_rr;
    bit tmo, err, orr, e_iar, e_dar, e_ivl, e_dvl, e_mrr, e_mav;
    logic [31:0] e_rd;
    logic [1:0] e_gnt;
    string p;
    for (int k = 0; k < 2; k++) mprev_g[k] = 2'b00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        p = $sformatf("u%0d_", k);
        win = 0; err = 0; orr = 0; tmo = 0;
        e_iar = 0; e_dar = 0; e_ivl = 0; e_dvl = 0; e_mrr = 0;
        e_rd = 32'd0; e_rr = 0;
        if (!rst_n) begin
          mstage[k] = 0; mowner[k] = 0; mwaited[k] = 0;
          mlastd[k] = 1; merrh[k] = 0; maddr[k] = 32'd0;
        end else begin
          if (mstage[k] == 0) begin
            if (i_arvalid && d_arvalid) win = !fair_of(k) ? 2 : (mlastd[k] ? 1 : 2);
            else if (i_arvalid) win = 1;
            else if (d_arvalid) win = 2;
          end
          if (mstage[k] == 2) begin
            orr = (mowner[k] == 1) ? i_rready : d_rready;
            tmo = (to_of(k) != 0) && (mwaited[k] >= to_of(k));
            err = merrh[k] || (tmo && !m_rvalid);
            e_ivl = (mowner[k] == 1) && (err || m_rvalid);
            e_dvl = (mowner[k] == 2) && (err || m_rvalid);
            e_rd  = err ? 32'd0 : m_rdata;
            e_rr  = err ? 2 : int'(m_rresp);
            e_mrr = !err && orr;
          end
          if (mstage[k] == 3) e_mrr = 1;
          e_iar = (win == 1);
          e_dar = (win == 2);
        end
        e_mav = (mstage[k] == 1);
        e_gnt = (mstage[k] == 1 || mstage[k] == 2) ? 2'(mowner[k]) : 2'b00;

        chk1({p, "i_arready"}, o_iar[k], e_iar);
        chk1({p, "d_arready"}, o_dar[k], e_dar);
        chk1({p, "i_rvalid"},  o_ivl[k], e_ivl);
        chk1({p, "d_rvalid"},  o_dvl[k], e_dvl);
        chk1({p, "m_arvalid"}, o_mav[k], e_mav);
        chk1({p, "m_rready"},  o_mrr[k], e_mrr);
        chk32({p, "m_araddr"}, o_mad[k], maddr[k]);
        chk32({p, "gnt"}, {30'd0, o_gnt[k]}, {30'd0, e_gnt});
        if (e_ivl) begin
          chk32({p, "i_rdata"}, o_ird[k], e_rd);
          chk32({p, "i_rresp"}, {30'd0, o_irr[k]}, 32'(e_rr));
        end
        if (e_dvl) begin
          chk32({p, "d_rdata"}, o_drd[k], e_rd);
          chk32({p, "d_rresp"}, {30'd0, o_drr[k]}, 32'(e_rr));
        end

        if (rst_n && o_gnt[k] != 2'b00 && mprev_g[k] == 2'b00) begin
          if (k == 0) glog0.push_back(int'(o_gnt[k]));
          else        glog1.push_back(int'(o_gnt[k]));
        end
        mprev_g[k] = o_gnt[k];

        if (rst_n) begin
          case (mstage[k])
            0: if (win != 0) begin
                 mowner[k] = win;
                 maddr[k]  = (win == 1) ? i_araddr : d_araddr;
                 mlastd[k] = (win == 2);
                 mstage[k] = 1;
               end
            1: if (m_arready) begin
                 mstage[k] = 2; mwaited[k] = 0; merrh[k] = 0;
               end
            2: if (err) begin
                 if (orr) mstage[k] = 3;
                 else     merrh[k] = 1;
               end else if (m_rvalid && orr) begin
                 mstage[k] = 0;
               end else begin
                 mwaited[k]++;
               end
            3: if (m_rvalid) mstage[k] = 0;
            default: mstage[k] = 0;
          endcase
        end
      end
    end
  end

  // Inputs change 1ns after a rising edge; literal checks happen at +3ns.
  task automatic set_in(input logic iv, input logic [31:0] ia, input logic dv,
                        input logic [31:0] da, input logic ir, input logic dr,
                        input logic mar, input logic mrv, input logic [31:0] mrd,
                        input logic [1:0] mrr);
    i_arvalid = iv; i_araddr = ia; d_arvalid = dv; d_araddr = da;
    i_rready = ir; d_rready = dr; m_arready = mar; m_rvalid = mrv;
    m_rdata = mrd; m_rresp = mrr;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    chk32("rst_gnt", {30'd0, o_gnt[0]}, 32'd0);
    chk32("rst_araddr", o_mad[0], 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_rr[8] = '{1, 2, 1, 2, 1, 2, 1, 2};

  initial begin
    idle_in();
    @(posedge clk);
    #1;

    // 1: single fetch, memory ready one cycle later, data one cycle after that
    do_reset();
    set_in(1, 32'h8000_0000, 0, 0, 1, 1, 0, 0, 0, 2'b00);
    chk1("t1_iar", o_iar[0], 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    chk1("t1_mav", o_mav[0], 1'b1);
    chk32("t1_mad", o_mad[0], 32'h8000_0000);
    chk32("t1_gnt", {30'd0, o_gnt[0]}, 32'd1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 1, 32'h13, 2'b00);
    chk1("t1_ivl", o_ivl[0], 1'b1);
    chk32("t1_ird", o_ird[0], 32'h13);
    chk1("t1_dvl", o_dvl[0], 1'b0);
    tick();
    idle_in();
    chk32("t1_gnt_end", {30'd0, o_gnt[0]}, 32'd0);
    tick();

    // 2: both masters always valid, memory always ready
    do_reset();
    glog0.delete();
    glog1.delete();
    for (int c = 0; c < 24; c++) begin
      set_in(1, 32'h100, 1, 32'h200, 1, 1, 1, 1, 32'(c + 32'h500), 2'b00);
      if (c == 0) begin
        chk1("t2_first_i_rr", o_iar[0], 1'b1);
        chk1("t2_first_d_fx", o_dar[1], 1'b1);
      end
      tick();
    end
    idle_in();
    tick();
    chk32("t2_rr_count", 32'(glog0.size()), 32'd8);
    chk32("t2_fx_count", 32'(glog1.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      if (j < glog0.size()) chk32($sformatf("t2_rr_gnt%0d", j), 32'(glog0[j]), 32'(exp_rr[j]));
      if (j < glog1.size()) chk32($sformatf("t2_fx_gnt%0d", j), 32'(glog1[j]), 32'd2);
    end

    // 3: address held while memory stalls; d_arvalid toggling ignored
    do_reset();
    set_in(0, 0, 1, 32'h1000, 1, 1, 0, 0, 0, 2'b00);
    chk1("t3_dar", o_dar[0], 1'b1);
    tick();
    for (int j = 0; j < 3; j++) begin
      set_in(0, 0, (j != 1), 32'h2222, 1, 1, 0, 0, 0, 2'b00);
      chk1($sformatf("t3_mav%0d", j), o_mav[0], 1'b1);
      chk32($sformatf("t3_mad%0d", j), o_mad[0], 32'h1000);
      chk1($sformatf("t3_dar%0d", j), o_dar[0], 1'b0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    chk1("t3_mav_last", o_mav[0], 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 1, 32'hABCD, 2'b00);
    chk1("t3_dvl", o_dvl[0], 1'b1);
    chk32("t3_drd", o_drd[0], 32'hABCD);
    tick();
    idle_in();
    tick();

    // 4: owner back-pressure for 4 cycles, pending d request must wait
    do_reset();
    set_in(1, 32'h40, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    tick();
    for (int j = 0; j < 4; j++) begin
      set_in(0, 0, 1, 32'h50, 0, 1, 0, 1, 32'h77, 2'b01);
      chk1($sformatf("t4_mrr%0d", j), o_mrr[0], 1'b0);
      chk1($sformatf("t4_ivl%0d", j), o_ivl[0], 1'b1);
      chk1($sformatf("t4_dar%0d", j), o_dar[0], 1'b0);
      tick();
    end
    set_in(0, 0, 1, 32'h50, 1, 1, 0, 1, 32'h77, 2'b01);
    chk1("t4_mrr_hs", o_mrr[0], 1'b1);
    chk32("t4_ird", o_ird[0], 32'h77);
    chk32("t4_irr", {30'd0, o_irr[0]}, 32'd1);
    chk1("t4_dar_hs", o_dar[0], 1'b0);
    tick();
    set_in(0, 0, 1, 32'h50, 1, 1, 0, 0, 0, 2'b00);
    chk1("t4_dar_next", o_dar[0], 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 1, 32'h88, 2'b00);
    chk1("t4_dvl", o_dvl[0], 1'b1);
    tick();
    idle_in();
    tick();

    // 5: watchdog error, drain of the late beat, then a normal transaction
    do_reset();
    set_in(1, 32'h60, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    tick();
    for (int j = 0; j < 4; j++) begin
      idle_in();
      chk1($sformatf("t5_quiet%0d", j), o_ivl[0], 1'b0);
      tick();
    end
    idle_in();
    chk1("t5_err_vl", o_ivl[0], 1'b1);
    chk32("t5_err_rr", {30'd0, o_irr[0]}, 32'd2);
    chk32("t5_err_rd", o_ird[0], 32'd0);
    chk1("t5_err_mrr", o_mrr[0], 1'b0);
    chk1("t5_fx_vl", o_ivl[1], 1'b0);
    tick();
    idle_in();
    chk1("t5_hold_vl", o_ivl[0], 1'b1);
    chk32("t5_hold_rr", {30'd0, o_irr[0]}, 32'd2);
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    chk1("t5_acc_vl", o_ivl[0], 1'b1);
    tick();
    set_in(1, 32'h44, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    chk32("t5_drain_gnt", {30'd0, o_gnt[0]}, 32'd0);
    chk1("t5_drain_mrr", o_mrr[0], 1'b1);
    chk1("t5_drain_iar", o_iar[0], 1'b0);
    tick();
    set_in(1, 32'h44, 0, 0, 1, 0, 0, 1, 32'hDEAD, 2'b00);
    chk1("t5_late_ivl", o_ivl[0], 1'b0);
    chk1("t5_late_iar", o_iar[0], 1'b0);
    tick();
    set_in(1, 32'h44, 0, 0, 1, 0, 0, 0, 0, 2'b00);
    chk1("t5_regrant", o_iar[0], 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00);
    chk32("t5_mad", o_mad[0], 32'h44);
    tick();
    set_in(0, 0, 0, 0, 1, 0, 0, 1, 32'h55, 2'b00);
    chk1("t5_ivl", o_ivl[0], 1'b1);
    chk32("t5_ird", o_ird[0], 32'h55);
    tick();
    idle_in();
    tick();

    // 6a: reset while the address is stalled at memory
    do_reset();
    set_in(0, 0, 1, 32'h900, 1, 1, 0, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00);
    chk1("t6_mav_pre", o_mav[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_mav_async", o_mav[0], 1'b0);
    chk32("t6_mad_async", o_mad[0], 32'd0);
    chk32("t6_gnt_async", {30'd0, o_gnt[0]}, 32'd0);
    tick();
    idle_in();
    tick();
    rst_n = 1'b1;

    // 6b: reset during WAIT_R abandons the response
    set_in(1, 32'h300, 0, 0, 1, 1, 0, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 1, 32'h99, 2'b00);
    chk1("t6_ivl_pre", o_ivl[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_ivl_async", o_ivl[0], 1'b0);
    chk1("t6_mrr_async", o_mrr[0], 1'b0);
    chk32("t6_gnt_async2", {30'd0, o_gnt[0]}, 32'd0);
    tick();
    idle_in();
    tick();
    rst_n = 1'b1;
    set_in(1, 32'h304, 0, 0, 1, 1, 0, 0, 0, 2'b00);
    chk1("t6_iar", o_iar[0], 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00);
    chk32("t6_mad", o_mad[0], 32'h304);
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0, 1, 32'h5A, 2'b00);
    chk1("t6_ivl", o_ivl[0], 1'b1);
    chk32("t6_ird", o_ird[0], 32'h5A);
    tick();
    idle_in();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
